snake_move_ctrl: RTL and testbench



---
 rtl/snake_move_ctrl_if.sv | 35 +++
 rtl/snake_move_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_snake_move_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_move_ctrl_if.sv
// Game/renderer side of the snake move sequencer: move
// control, status, and the segment read port.
interface snake_move_ctrl_if #(
  parameter int XW = 6,
  parameter int YW = 5,
  parameter int LW = 6
) ();
  logic          init;
  logic          step;
  logic [1:0]    dir;
  logic [XW-1:0] food_x;
  logic [YW-1:0] food_y;
  logic          busy;
  logic          done;
  logic          ate;
  logic          dead;
  logic [LW-1:0] length;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic [LW-1:0] rd_addr;
  logic [XW-1:0] rd_x;
  logic [YW-1:0] rd_y;

  modport master (
    output init, step, dir, food_x, food_y, rd_addr,
    input  busy, done, ate, dead, length,
    input  head_x, head_y, rd_x, rd_y
  );

  modport slave (
    input  init, step, dir, food_x, food_y, rd_addr,
    output busy, done, ate, dead, length,
    output head_x, head_y, rd_x, rd_y
  );
endinterface

// File: rtl/snake_move_ctrl.sv
// One snake move per step: new head, wall/self collision,
// food detection, body shift. Owns the segment store.
module snake_move_ctrl #(
  parameter int COLS    = 40,
  parameter int ROWS    = 30,
  parameter int MAX_LEN = 32,
  parameter int XW      = 6,
  parameter int YW      = 5,
  parameter int LW      = 6
) (
  input  logic clk,
  input  logic rst_n,
  snake_move_ctrl_if.slave bus
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [LW-1:0] LEN0 = LW'(3);
  localparam logic [LW-1:0] MAXL = LW'(MAX_LEN);
  localparam logic [1:0]    RIGHT = 2'b11;

  typedef enum logic [2:0] {
    IDLE, CALC, SCAN, SHIFT, DONE, DEAD
  } state_t;

  state_t state, state_nx;

  logic [XW-1:0] seg_x [MAX_LEN];
  logic [YW-1:0] seg_y [MAX_LEN];

  logic [LW-1:0] len_q, idx, scan_n;
  logic [1:0]    heading, mv_dir;
  logic [XW-1:0] fx_q, nx_q, cx, rd_x_q;
  logic [YW-1:0] fy_q, ny_q, cy, rd_y_q;
  logic          eat_q, done_q, ate_q, dead_q;
  logic          wall, calc_eat, hit, last, rev;

  function automatic logic [XW-1:0] start_x(int i);
    return (i < 3) ? XW'(COLS / 2 - i) : '0;
  endfunction

  function automatic logic [YW-1:0] start_y(int i);
    return (i < 3) ? YW'(ROWS / 2) : '0;
  endfunction

  always_comb begin
    cx   = seg_x[0];
    cy   = seg_y[0];
    wall = 1'b0;
    unique case (mv_dir)
      2'b00: begin
        wall = (seg_y[0] == '0);
        cy   = seg_y[0] - YW'(1);
      end
      2'b01: begin
        wall = (seg_y[0] == YW'(ROWS - 1));
        cy   = seg_y[0] + YW'(1);
      end
      2'b10: begin
        wall = (seg_x[0] == '0);
        cx   = seg_x[0] - XW'(1);
      end
      2'b11: begin
        wall = (seg_x[0] == XW'(COLS - 1));
        cx   = seg_x[0] + XW'(1);
      end
    endcase
  end

  assign calc_eat = (cx == fx_q) && (cy == fy_q);
  assign hit  = (seg_x[idx[AW-1:0]] == nx_q)
             && (seg_y[idx[AW-1:0]] == ny_q);
  assign last = ((idx + LW'(1)) == scan_n);
  assign rev  = (bus.dir == {heading[1], ~heading[0]});

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.step) state_nx = CALC;
      CALC:  state_nx = wall ? DEAD : SCAN;
      SCAN: begin
        if (hit)       state_nx = DEAD;
        else if (last) state_nx = SHIFT;
      end
      SHIFT: state_nx = DONE;
      DONE:  state_nx = IDLE;
      DEAD:  state_nx = DEAD;
      default: state_nx = IDLE;
    endcase
    if (bus.init) state_nx = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= start_x(i);
        seg_y[i] <= start_y(i);
      end
    end else if (bus.init) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x[i] <= start_x(i);
        seg_y[i] <= start_y(i);
      end
    end else if (state == SHIFT) begin
      seg_x[0] <= nx_q;
      seg_y[0] <= ny_q;
      for (int i = 1; i < MAX_LEN; i++) begin
        seg_x[i] <= seg_x[i-1];
        seg_y[i] <= seg_y[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q   <= LEN0;
      heading <= RIGHT;
      mv_dir  <= RIGHT;
      idx     <= '0;
      scan_n  <= '0;
      fx_q    <= '0;
      fy_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
      eat_q   <= 1'b0;
      done_q  <= 1'b0;
      ate_q   <= 1'b0;
      dead_q  <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
    end else if (bus.init) begin
      len_q   <= LEN0;
      heading <= RIGHT;
      mv_dir  <= RIGHT;
      eat_q   <= 1'b0;
      done_q  <= 1'b0;
      ate_q   <= 1'b0;
      dead_q  <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
    end else begin
      // done is registered, so it trails DONE/entry to DEAD by one edge
      done_q <= (state == DONE) || (state == DEAD && !dead_q);
      ate_q  <= (state == DONE) && eat_q;
      if (state == DEAD) dead_q <= 1'b1;
      if (bus.rd_addr < len_q) begin
        rd_x_q <= seg_x[bus.rd_addr[AW-1:0]];
        rd_y_q <= seg_y[bus.rd_addr[AW-1:0]];
      end else begin
        rd_x_q <= '0;
        rd_y_q <= '0;
      end
      unique case (state)
        IDLE: if (bus.step) begin
          mv_dir <= rev ? heading : bus.dir;
          fx_q   <= bus.food_x;
          fy_q   <= bus.food_y;
        end
        CALC: begin
          nx_q   <= cx;
          ny_q   <= cy;
          eat_q  <= calc_eat;
          scan_n <= calc_eat ? len_q : len_q - LW'(1);
          idx    <= '0;
        end
        SCAN:  idx <= idx + LW'(1);
        SHIFT: begin
          heading <= mv_dir;
          if (eat_q && len_q < MAXL) len_q <= len_q + LW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy   = (state != IDLE) && (state != DEAD);
  assign bus.done   = done_q;
  assign bus.ate    = ate_q;
  assign bus.dead   = dead_q;
  assign bus.length = len_q;
  assign bus.head_x = seg_x[0];
  assign bus.head_y = seg_y[0];
  assign bus.rd_x   = rd_x_q;
  assign bus.rd_y   = rd_y_q;

endmodule

// File: tb/tb_snake_move_ctrl.sv
// Bench for snake_move_ctrl: vector table, corner sequences,
// and random moves against a queue-based snake model.
module tb_snake_move_ctrl;
  localparam int COLS = 40;
  localparam int ROWS = 30;
  localparam int MAXL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  snake_move_ctrl_if #(.XW(6), .YW(5), .LW(6)) bus ();

  snake_move_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .MAX_LEN(MAXL),
    .XW(6), .YW(5), .LW(6)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  typedef struct {
    int x;
    int y;
  } pt_t;

  pt_t body[$];
  int  hd;
  bit  m_dead;

  function automatic int opp(int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  function automatic int ddx(int d);
    return (d == 2) ? -1 : (d == 3) ? 1 : 0;
  endfunction

  function automatic int ddy(int d);
    return (d == 0) ? -1 : (d == 1) ? 1 : 0;
  endfunction

  task automatic m_reset();
    pt_t p;
    body = {};
    for (int i = 0; i < 3; i++) begin
      p.x = COLS / 2 - i;
      p.y = ROWS / 2;
      body.push_back(p);
    end
    hd = 3;
    m_dead = 1'b0;
  endtask

  task automatic m_step(input int d, input int fx, input int fy,
                        output int lat, output int ate);
    int e, n;
    bit eat;
    pt_t h;
    lat = 0;
    ate = 0;
    if (m_dead) return;
    e = (d == opp(hd)) ? hd : d;
    h = body[0];
    h.x += ddx(e);
    h.y += ddy(e);
    if (h.x < 0 || h.x >= COLS || h.y < 0 || h.y >= ROWS) begin
      m_dead = 1'b1;
      lat = 2;
      return;
    end
    eat = (h.x == fx) && (h.y == fy);
    n = eat ? body.size() : body.size() - 1;
    for (int k = 0; k < n; k++) begin
      if (body[k].x == h.x && body[k].y == h.y) begin
        m_dead = 1'b1;
        lat = k + 3;
        return;
      end
    end
    body.push_front(h);
    if (!eat || body.size() > MAXL) void'(body.pop_back());
    hd = e;
    ate = int'(eat);
    lat = n + 3;
  endtask

  task automatic dut_step(input int d, input int fx, input int fy,
                          output int lat, output int ate);
    @(negedge clk);
    bus.step = 1'b1;
    bus.dir = 2'(d);
    bus.food_x = 6'(fx);
    bus.food_y = 5'(fy);
    @(negedge clk);
    bus.step = 1'b0;
    lat = 0;
    ate = 0;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = c;
        ate = int'(bus.ate);
        break;
      end
    end
  endtask

  task automatic do_init();
    @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    m_reset();
  endtask

  task automatic check_segs(input string tag);
    int ex, ey;
    for (int i = 0; i <= body.size(); i++) begin
      @(negedge clk);
      bus.rd_addr = 6'(i);
      @(posedge clk);
      #1;
      ex = (i < body.size()) ? body[i].x : 0;
      ey = (i < body.size()) ? body[i].y : 0;
      chk({tag, " rd_x"}, int'(bus.rd_x), ex);
      chk({tag, " rd_y"}, int'(bus.rd_y), ey);
    end
  endtask

  task automatic step_chk(input string tag, input int d,
                          input int fx, input int fy);
    int el, ea, al, aa;
    m_step(d, fx, fy, el, ea);
    dut_step(d, fx, fy, al, aa);
    chk({tag, " latency"}, al, el);
    chk({tag, " ate"}, aa, ea);
    chk({tag, " dead"}, int'(bus.dead), int'(m_dead));
    chk({tag, " length"}, int'(bus.length), body.size());
    chk({tag, " head_x"}, int'(bus.head_x), body[0].x);
    chk({tag, " head_y"}, int'(bus.head_y), body[0].y);
    check_segs(tag);
  endtask

  typedef struct {
    bit do_init;
    int d, fx, fy;
    int lat, ate, dead, len, hx, hy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached, want summary");
    $fatal(1, "timeout");
  end

  initial begin
    int al, aa, cnt, fx, fy, d, e;
    tbl[0] = '{1, 3,  0,  0, 5, 0, 0, 3, 21, 15};
    tbl[1] = '{1, 2,  0,  0, 5, 0, 0, 3, 21, 15};
    tbl[2] = '{1, 3, 21, 15, 6, 1, 0, 4, 21, 15};
    tbl[3] = '{0, 3, 22, 15, 7, 1, 0, 5, 22, 15};
    tbl[4] = '{0, 0,  0,  0, 7, 0, 0, 5, 22, 14};
    tbl[5] = '{0, 2,  0,  0, 7, 0, 0, 5, 21, 14};
    tbl[6] = '{0, 1,  0,  0, 6, 0, 1, 5, 21, 14};
    tbl[7] = '{0, 3,  0,  0, 0, 0, 1, 5, 21, 14};

    bus.init = 1'b0;
    bus.step = 1'b0;
    bus.dir = 2'b00;
    bus.food_x = '0;
    bus.food_y = '0;
    bus.rd_addr = 6'd1;
    m_reset();

    repeat (2) @(negedge clk);
    chk("reset rd_x", int'(bus.rd_x), 0);
    chk("reset rd_y", int'(bus.rd_y), 0);
    chk("reset done", int'(bus.done), 0);
    chk("reset dead", int'(bus.dead), 0);
    rst_n = 1'b1;
    chk("reset length", int'(bus.length), 3);
    chk("reset head_x", int'(bus.head_x), 20);
    chk("reset head_y", int'(bus.head_y), 15);
    chk("reset busy", int'(bus.busy), 0);
    @(posedge clk);
    #1;
    chk("reset rd1_x", int'(bus.rd_x), 19);
    chk("reset rd1_y", int'(bus.rd_y), 15);

    foreach (tbl[i]) begin
      if (tbl[i].do_init) do_init();
      dut_step(tbl[i].d, tbl[i].fx, tbl[i].fy, al, aa);
      chk($sformatf("vec%0d latency", i), al, tbl[i].lat);
      chk($sformatf("vec%0d ate", i), aa, tbl[i].ate);
      chk($sformatf("vec%0d dead", i), int'(bus.dead), tbl[i].dead);
      chk($sformatf("vec%0d length", i), int'(bus.length), tbl[i].len);
      chk($sformatf("vec%0d head_x", i), int'(bus.head_x), tbl[i].hx);
      chk($sformatf("vec%0d head_y", i), int'(bus.head_y), tbl[i].hy);
    end

    // second step pulse while busy must not start another move
    do_init();
    m_step(3, 0, 0, al, aa);
    @(negedge clk);
    bus.step = 1'b1;
    bus.dir = 2'b11;
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
    chk("busy-step done count", cnt, 1);
    chk("busy-step head_x", int'(bus.head_x), body[0].x);
    check_segs("busy-step");

    do_init();
    for (int s = 0; s < 16; s++) step_chk("wall", 0, 0, 0);
    chk("wall head_y", int'(bus.head_y), 0);
    step_chk("wall-ignored", 0, 0, 0);
    do_init();
    chk("wall init dead", int'(bus.dead), 0);
    chk("wall init length", int'(bus.length), 3);
    chk("wall init head_x", int'(bus.head_x), 20);
    chk("wall init head_y", int'(bus.head_y), 15);

    // init lands while the scan is in progress
    do_init();
    @(negedge clk);
    bus.step = 1'b1;
    bus.dir = 2'b11;
    @(negedge clk);
    bus.step = 1'b0;
    repeat (2) @(negedge clk);
    bus.init = 1'b1;
    @(negedge clk);
    bus.init = 1'b0;
    chk("midscan busy", int'(bus.busy), 0);
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (bus.done) cnt++;
    end
    chk("midscan done count", cnt, 0);
    chk("midscan head_x", int'(bus.head_x), 20);
    chk("midscan length", int'(bus.length), 3);
    check_segs("midscan");

    // eat on every move to reach and overrun full length
    do_init();
    for (int s = 0; s < 31; s++) begin
      d = (s < 19) ? 3 : (s == 19) ? 1 : 2;
      step_chk("grow", d, body[0].x + ddx(d), body[0].y + ddy(d));
    end
    chk("grow final length", int'(bus.length), MAXL);

    do_init();
    for (int s = 0; s < 150; s++) begin
      d = $urandom_range(0, 3);
      e = (d == opp(hd)) ? hd : d;
      fx = body[0].x + ddx(e);
      fy = body[0].y + ddy(e);
      if ($urandom_range(0, 1) == 0 || fx < 0 || fx >= COLS
          || fy < 0 || fy >= ROWS) begin
        fx = $urandom_range(0, COLS - 1);
        fy = $urandom_range(0, ROWS - 1);
      end
      step_chk("rand", d, fx, fy);
      if (m_dead) do_init();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
